// File: rtl/wb_scoreboard.sv
// Writeback arbiter and load busy-scoreboard in front of the single register-file write port.
// Latency: 1 cycle from an ALU result or a load handshake to the register-file write.
// Backpressure: ALU never stalls; o_ld_ready = !i_alu_valid; decode held via o_issue_stall on busy hazards.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_issue_*  / o_issue_stall       decode presentation and hazard stall (combinational)
//   i_alu_valid/rd/data              single-cycle ALU result, fixed priority
//   i_ld_valid/rd/data, o_ld_ready   load unit result with valid/ready handshake
//   o_wb_we/rd/wd                    registered register-file write port
// Optional feature macro: SB_EARLY_RELEASE_EN -- a register released by a load handshake
//   this cycle no longer causes a hazard in that same cycle.
module wb_scoreboard #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_issue_valid,
   input  logic [AW-1:0]   i_issue_rd,
   input  logic [AW-1:0]   i_issue_rs1,
   input  logic [AW-1:0]   i_issue_rs2,
   input  logic            i_issue_uses_rs1,
   input  logic            i_issue_uses_rs2,
   input  logic            i_issue_long,
   output logic            o_issue_stall,
   input  logic            i_alu_valid,
   input  logic [AW-1:0]   i_alu_rd,
   input  logic [XLEN-1:0] i_alu_data,
   input  logic            i_ld_valid,
   input  logic [AW-1:0]   i_ld_rd,
   input  logic [XLEN-1:0] i_ld_data,
   output logic            o_ld_ready,
   output logic            o_wb_we,
   output logic [AW-1:0]   o_wb_rd,
   output logic [XLEN-1:0] o_wb_wd
);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;
   logic [NREGS-1:0] w_busy_eff;
   logic             w_ld_fire;
   logic             w_hz_rs1;
   logic             w_hz_rs2;
   logic             w_hz_rd;
   logic             w_accept;
   logic             r_wb_we;
   logic [AW-1:0]    r_wb_rd;
   logic [XLEN-1:0]  r_wb_wd;

   // ALU owns the write port whenever it has a result; loads wait in the load unit.
   assign o_ld_ready = ~i_alu_valid;
   assign w_ld_fire  = i_ld_valid & ~i_alu_valid;

`ifdef SB_EARLY_RELEASE_EN
   // The register being written back by this cycle's load is treated as free already;
   // execute-stage forwarding supplies the value to the dependent instruction.
   logic [NREGS-1:0] w_rel_mask;
   always_comb begin
      w_rel_mask = '0;
      if (w_ld_fire) w_rel_mask[i_ld_rd] = 1'b1;
   end
   assign w_busy_eff = r_busy & ~w_rel_mask;
`else
   assign w_busy_eff = r_busy;
`endif

   assign w_hz_rs1 = i_issue_uses_rs1 & (i_issue_rs1 != '0) & w_busy_eff[i_issue_rs1];
   assign w_hz_rs2 = i_issue_uses_rs2 & (i_issue_rs2 != '0) & w_busy_eff[i_issue_rs2];
   assign w_hz_rd  = (i_issue_rd != '0) & w_busy_eff[i_issue_rd];

   assign o_issue_stall = i_issue_valid & (w_hz_rs1 | w_hz_rs2 | w_hz_rd);
   assign w_accept      = i_issue_valid & ~o_issue_stall;

   // Clear is applied before set so a same-cycle set of the same bit wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_ld_fire && (i_ld_rd != '0))
         w_busy_nxt[i_ld_rd] = 1'b0;
      if (w_accept && i_issue_long && (i_issue_rd != '0))
         w_busy_nxt[i_issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy  <= '0;
         r_wb_we <= 1'b0;
         r_wb_rd <= '0;
         r_wb_wd <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (i_alu_valid) begin
            r_wb_we <= (i_alu_rd != '0);
            r_wb_rd <= i_alu_rd;
            r_wb_wd <= i_alu_data;
         end else if (w_ld_fire) begin
            r_wb_we <= (i_ld_rd != '0);
            r_wb_rd <= i_ld_rd;
            r_wb_wd <= i_ld_data;
         end else begin
            // Idle: drop the enable, keep index/data stable.
            r_wb_we <= 1'b0;
         end
      end
   end

   assign o_wb_we = r_wb_we;
   assign o_wb_rd = r_wb_rd;
   assign o_wb_wd = r_wb_wd;

endmodule
